// File: rtl/branch_operand_forwarder.sv
// ID-stage branch operand forwarder: tag-priority bypass with load-use stall and timeout.
// Optional counters behind FWD_STATS_EN (fwd_count, stall_count, stats_clr).
module branch_operand_forwarder #(
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 4,
  parameter int NPORTS    = 2,
  parameter int STAGES    = 3,
  parameter int MAX_STALL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NPORTS*REG_AW-1:0] id_src,
  input  logic [NPORTS*DATA_W-1:0] id_rd,
  input  logic [STAGES-1:0]        stg_valid,
  input  logic [STAGES*REG_AW-1:0] stg_dst,
  input  logic [STAGES*DATA_W-1:0] stg_data,
  input  logic [STAGES-1:0]        stg_ready,
  output logic [NPORTS*DATA_W-1:0] op_out,
  output logic                     op_valid,
  output logic [NPORTS*2-1:0]      fwd_sel,
  output logic                     stall,
  output logic                     hazard_timeout
`ifdef FWD_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [15:0]              fwd_count,
  output logic [15:0]              stall_count
`endif
);

  localparam int CW = $clog2(MAX_STALL + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t                   state;
  logic [CW-1:0]            stall_cnt;
  logic                     hazard;
  logic                     fwd_any;
  logic                     capture;
  logic [NPORTS*DATA_W-1:0] res_bus;
  logic [NPORTS*2-1:0]      sel_bus;

  always_comb begin
    logic [REG_AW-1:0] src;
    logic              hit;
    logic              rdy;
    logic [DATA_W-1:0] val;
    logic [1:0]        sel;
    hazard  = 1'b0;
    fwd_any = 1'b0;
    res_bus = '0;
    sel_bus = '0;
    for (int p = 0; p < NPORTS; p++) begin
      src = id_src[p*REG_AW +: REG_AW];
      hit = 1'b0;
      rdy = 1'b1;
      val = id_rd[p*DATA_W +: DATA_W];
      sel = 2'd0;
      // oldest first so the youngest hit overwrites
      for (int s = STAGES - 1; s >= 0; s--) begin
        if (stg_valid[s] && stg_dst[s*REG_AW +: REG_AW] == src) begin
          hit = 1'b1;
          rdy = stg_ready[s];
          val = stg_data[s*DATA_W +: DATA_W];
          sel = (s >= 2) ? 2'd3 : 2'(s + 1);
        end
      end
      if (src == '0) begin
        hit = 1'b0;
        rdy = 1'b1;
        val = '0;
        sel = 2'd0;
      end
      res_bus[p*DATA_W +: DATA_W] = val;
      sel_bus[p*2 +: 2]           = sel;
      fwd_any = fwd_any | hit;
      hazard  = hazard | (id_valid & hit & ~rdy);
    end
  end

  assign stall   = hazard & rst_n;
  assign capture = id_valid & ~hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_out         <= '0;
      op_valid       <= 1'b0;
      fwd_sel        <= '0;
      hazard_timeout <= 1'b0;
      state          <= RUN;
      stall_cnt      <= '0;
    end else begin
      op_valid <= capture;
      if (capture) begin
        op_out  <= res_bus;
        fwd_sel <= sel_bus;
      end
      unique case (state)
        RUN: begin
          if (hazard) begin
            state     <= STALL;
            stall_cnt <= CW'(1);
          end
        end
        STALL: begin
          if (!hazard) begin
            state     <= RUN;
            stall_cnt <= '0;
          end else if (stall_cnt == CW'(MAX_STALL)) begin
            hazard_timeout <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + CW'(1);
          end
        end
        default: begin
          state     <= RUN;
          stall_cnt <= '0;
        end
      endcase
    end
  end

`ifdef FWD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else if (stats_clr) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else begin
      if (capture && fwd_any && fwd_count != 16'hFFFF)
        fwd_count <= fwd_count + 16'd1;
      if (hazard && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
